// File: rtl/nab_axi_lite_regfile_pkg.sv
// Register map, FSM state types and the byte-lane merge helper shared by the
// AXI4-Lite register file of the neuromorphic ASIC bridge.
package nab_axi_lite_regfile_pkg;

  // Word indices (byte offset >> 2); the decoder only looks at addr[5:2].
  localparam logic [3:0] CharSelectReg    = 4'h0;
  localparam logic [3:0] NetworkOutputReg = 4'h1;
  localparam logic [3:0] DirectCtrlReg    = 4'h2;
  localparam logic [3:0] DebugReg         = 4'h3;
  localparam logic [3:0] Aux0Reg          = 4'h4;
  localparam logic [3:0] Aux1Reg          = 4'h5;
  localparam logic [3:0] Aux2Reg          = 4'h6;
  localparam logic [3:0] Aux3Reg          = 4'h7;
  localparam logic [3:0] PwmClkDivReg     = 4'h8;
  localparam logic [3:0] PwmDutyReg       = 4'h9;
  localparam logic [3:0] PwmCntrReg       = 4'hA;
  localparam logic [3:0] PmodDacReg       = 4'hB;

  localparam logic [1:0] RespOkay = 2'b00;

  typedef enum logic [0:0] {WIdle, WResp} wr_state_e;
  typedef enum logic [0:0] {RIdle, RData} rd_state_e;

  // With use_strb clear every lane is written regardless of strb.
  function automatic logic [31:0] merge_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb,
                                              input logic        use_strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (!use_strb || strb[i]) begin
        res[8*i +: 8] = new_val[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/nab_axi_lite_regfile_if.sv
// AXI4-Lite bus bundle between the CPU/bench (master) and the register file (slave).
interface nab_axi_lite_regfile_if #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;

  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;

  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/nab_axi_lite_regfile.sv
// AXI4-Lite responder holding the bridge control registers and returning live status on reads.
// Write and read channels run independent two-state FSMs, one outstanding transaction each.
module nab_axi_lite_regfile
  import nab_axi_lite_regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned USE_WSTRB  = 0
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  nab_axi_lite_regfile_if.slave s_axi,

  output logic [DATA_WIDTH-1:0] char_select_o,
  output logic [DATA_WIDTH-1:0] direct_ctrl_o,
  output logic [DATA_WIDTH-1:0] debug_o,
  output logic [DATA_WIDTH-1:0] pwm_clk_div_o,
  output logic [DATA_WIDTH-1:0] pwm_duty_o,
  output logic [DATA_WIDTH-1:0] pmod_dac_o,
  output logic                  pmod_dac_wr_o,

  input  logic [DATA_WIDTH-1:0] network_output_i,
  input  logic [DATA_WIDTH-1:0] aux0_i,
  input  logic [DATA_WIDTH-1:0] aux1_i,
  input  logic [DATA_WIDTH-1:0] aux2_i,
  input  logic [DATA_WIDTH-1:0] aux3_i,
  input  logic [DATA_WIDTH-1:0] pwm_cntr_i
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;
  localparam logic        UseStrb   = (USE_WSTRB != 0);

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  wr_state_e             wr_state_q, wr_state_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [3:0]            aw_idx_q, aw_idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [StrbWidth-1:0]  wstrb_q, wstrb_d;
  logic                  wr_en;

  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = 1'b0;
    wready_d   = 1'b0;
    bvalid_d   = bvalid_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wr_en      = 1'b0;

    unique case (wr_state_q)
      WIdle: begin
        if (awready_q && s_axi.awvalid) begin
          aw_held_d = 1'b1;
          aw_idx_d  = s_axi.awaddr[5:2];
        end
        if (wready_q && s_axi.wvalid) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi.wdata;
          wstrb_d  = s_axi.wstrb;
        end
        if (aw_held_q && w_held_q) begin
          wr_en      = 1'b1;
          bvalid_d   = 1'b1;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wr_state_d = WResp;
        end else begin
          // Single-cycle ready pulse per channel; held channels stay closed.
          awready_d = s_axi.awvalid && !aw_held_q && !awready_q;
          wready_d  = s_axi.wvalid && !w_held_q && !wready_q;
        end
      end
      WResp: begin
        if (s_axi.bready) begin
          bvalid_d   = 1'b0;
          wr_state_d = WIdle;
        end
      end
      default: wr_state_d = WIdle;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_state_q <= WIdle;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
    end
  end

  // ---------------------------------------------------------------------------
  // RW register bank
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] char_select_q, direct_ctrl_q, debug_q;
  logic [DATA_WIDTH-1:0] pwm_clk_div_q, pwm_duty_q, pmod_dac_q;
  logic                  pmod_dac_wr_q;

  // RO and unmapped indices fall into the default arm and change nothing.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      char_select_q <= '0;
      direct_ctrl_q <= '0;
      debug_q       <= '0;
      pwm_clk_div_q <= '0;
      pwm_duty_q    <= '0;
      pmod_dac_q    <= '0;
      pmod_dac_wr_q <= 1'b0;
    end else begin
      pmod_dac_wr_q <= wr_en && (aw_idx_q == PmodDacReg);
      if (wr_en) begin
        case (aw_idx_q)
          CharSelectReg: char_select_q <= merge_wstrb(char_select_q, wdata_q, wstrb_q, UseStrb);
          DirectCtrlReg: direct_ctrl_q <= merge_wstrb(direct_ctrl_q, wdata_q, wstrb_q, UseStrb);
          DebugReg:      debug_q       <= merge_wstrb(debug_q, wdata_q, wstrb_q, UseStrb);
          PwmClkDivReg:  pwm_clk_div_q <= merge_wstrb(pwm_clk_div_q, wdata_q, wstrb_q, UseStrb);
          PwmDutyReg:    pwm_duty_q    <= merge_wstrb(pwm_duty_q, wdata_q, wstrb_q, UseStrb);
          PmodDacReg:    pmod_dac_q    <= merge_wstrb(pmod_dac_q, wdata_q, wstrb_q, UseStrb);
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  rd_state_e             rd_state_q, rd_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (s_axi.araddr[5:2])
      CharSelectReg:    rd_mux = char_select_q;
      NetworkOutputReg: rd_mux = network_output_i;
      DirectCtrlReg:    rd_mux = direct_ctrl_q;
      DebugReg:         rd_mux = debug_q;
      Aux0Reg:          rd_mux = aux0_i;
      Aux1Reg:          rd_mux = aux1_i;
      Aux2Reg:          rd_mux = aux2_i;
      Aux3Reg:          rd_mux = aux3_i;
      PwmClkDivReg:     rd_mux = pwm_clk_div_q;
      PwmDutyReg:       rd_mux = pwm_duty_q;
      PwmCntrReg:       rd_mux = pwm_cntr_i;
      PmodDacReg:       rd_mux = pmod_dac_q;
      default:          rd_mux = '0;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = 1'b0;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;

    unique case (rd_state_q)
      RIdle: begin
        if (arready_q && s_axi.arvalid) begin
          // Sampled before this edge's register update, so a same-cycle write reads old.
          rdata_d    = rd_mux;
          rvalid_d   = 1'b1;
          rd_state_d = RData;
        end else begin
          arready_d = s_axi.arvalid && !arready_q;
        end
      end
      RData: begin
        if (s_axi.rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = RIdle;
        end
      end
      default: rd_state_d = RIdle;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_state_q <= RIdle;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = RespOkay;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = RespOkay;

  assign char_select_o = char_select_q;
  assign direct_ctrl_o = direct_ctrl_q;
  assign debug_o       = debug_q;
  assign pwm_clk_div_o = pwm_clk_div_q;
  assign pwm_duty_o    = pwm_duty_q;
  assign pmod_dac_o    = pmod_dac_q;
  assign pmod_dac_wr_o = pmod_dac_wr_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi.awaddr[ADDR_WIDTH-1:6], s_axi.awaddr[1:0],
                              s_axi.araddr[ADDR_WIDTH-1:6], s_axi.araddr[1:0]};

endmodule

// File: tb/tb_nab_axi_lite_regfile.sv
// Directed bench for nab_axi_lite_regfile: register map, channel ordering, back-pressure,
// PMOD write strobe, same-cycle read/write and reset abort.
module tb_nab_axi_lite_regfile;

  localparam logic [31:0] NetVal  = 32'h1111_0004;
  localparam logic [31:0] Aux0Val = 32'h2222_0010;
  localparam logic [31:0] Aux1Val = 32'h2222_0014;
  localparam logic [31:0] Aux2Val = 32'h2222_0018;
  localparam logic [31:0] Aux3Val = 32'h2222_001C;
  localparam logic [31:0] CntVal  = 32'h3333_0028;

  localparam logic [31:0] RstExp [12] = '{32'h0, NetVal, 32'h0, 32'h0, Aux0Val, Aux1Val,
                                          Aux2Val, Aux3Val, 32'h0, 32'h0, CntVal, 32'h0};
  localparam logic [8:0]  RwAddr [6]  = '{9'h00, 9'h08, 9'h0C, 9'h20, 9'h24, 9'h2C};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nab_axi_lite_regfile_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) axi ();

  logic [31:0] char_select, direct_ctrl, debug, pwm_clk_div, pwm_duty, pmod_dac;
  logic        pmod_dac_wr;

  nab_axi_lite_regfile #(
    .ADDR_WIDTH(9),
    .DATA_WIDTH(32),
    .USE_WSTRB (0)
  ) dut (
    .S_AXI_ACLK      (clk),
    .S_AXI_ARESETN   (rst_n),
    .s_axi           (axi),
    .char_select_o   (char_select),
    .direct_ctrl_o   (direct_ctrl),
    .debug_o         (debug),
    .pwm_clk_div_o   (pwm_clk_div),
    .pwm_duty_o      (pwm_duty),
    .pmod_dac_o      (pmod_dac),
    .pmod_dac_wr_o   (pmod_dac_wr),
    .network_output_i(NetVal),
    .aux0_i          (Aux0Val),
    .aux1_i          (Aux1Val),
    .aux2_i          (Aux2Val),
    .aux3_i          (Aux3Val),
    .pwm_cntr_i      (CntVal)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int pmod_pulses = 0;

  always @(negedge clk) if (pmod_dac_wr) pmod_pulses++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    axi.awaddr  = '0; axi.awvalid = 1'b0;
    axi.wdata   = '0; axi.wstrb   = 4'hF; axi.wvalid = 1'b0;
    axi.bready  = 1'b1;
    axi.araddr  = '0; axi.arvalid = 1'b0;
    axi.rready  = 1'b1;
  endtask

  task automatic do_reset();
    idle_bus();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Both channels presented together; returns once both handshakes have happened.
  task automatic send_aw_w(input logic [8:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit hs_aw, hs_w;
    int t = 0;
    axi.awaddr = addr; axi.awvalid = 1'b1;
    axi.wdata  = data; axi.wstrb   = strb; axi.wvalid = 1'b1;
    while (!(aw_done && w_done) && t < 20) begin
      hs_aw = axi.awvalid && axi.awready;
      hs_w  = axi.wvalid && axi.wready;
      step();
      if (hs_aw) begin axi.awvalid = 1'b0; aw_done = 1'b1; end
      if (hs_w)  begin axi.wvalid  = 1'b0; w_done  = 1'b1; end
      t++;
    end
    check_val("aw_w_accepted", {30'b0, aw_done, w_done}, 32'h3);
  endtask

  task automatic wait_b();
    int t = 0;
    while (!axi.bvalid && t < 10) begin step(); t++; end
    check_val("bvalid_seen", 32'(axi.bvalid), 32'h1);
    check_val("bresp_okay", 32'(axi.bresp), 32'h0);
    axi.bready = 1'b1;
    step();
  endtask

  task automatic axi_write(input logic [8:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    send_aw_w(addr, data, strb);
    wait_b();
  endtask

  task automatic axi_read(input logic [8:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int t = 0;
    axi.araddr = addr; axi.arvalid = 1'b1; axi.rready = 1'b1;
    while (!axi.arready && t < 10) begin step(); t++; end
    step();
    axi.arvalid = 1'b0;
    t = 0;
    while (!axi.rvalid && t < 10) begin step(); t++; end
    check_val("rvalid_seen", 32'(axi.rvalid), 32'h1);
    data = axi.rdata;
    resp = axi.rresp;
    step();
  endtask

  // One channel first, the other three idle cycles later. The later channel's data is
  // latched at its handshake edge and BVALID rises on the following edge.
  task automatic split_write(input logic [8:0] addr, input logic [31:0] data, input bit aw_first);
    int t = 0;
    if (aw_first) begin axi.awaddr = addr; axi.awvalid = 1'b1; end
    else begin axi.wdata = data; axi.wstrb = 4'hF; axi.wvalid = 1'b1; end
    while (!(aw_first ? axi.awready : axi.wready) && t < 10) begin step(); t++; end
    step();
    if (aw_first) axi.awvalid = 1'b0;
    else axi.wvalid = 1'b0;
    repeat (3) step();
    check_val("split_no_early_b", 32'(axi.bvalid), 32'h0);
    if (aw_first) begin axi.wdata = data; axi.wstrb = 4'hF; axi.wvalid = 1'b1; end
    else begin axi.awaddr = addr; axi.awvalid = 1'b1; end
    t = 0;
    while (!(aw_first ? axi.wready : axi.awready) && t < 10) begin step(); t++; end
    check_val("split_late_ready", 32'(aw_first ? axi.wready : axi.awready), 32'h1);
    step();
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    check_val("split_b_not_yet", 32'(axi.bvalid), 32'h0);
    step();
    check_val("split_b_rise", 32'(axi.bvalid), 32'h1);
    step();
    check_val("split_b_drop", 32'(axi.bvalid), 32'h0);
  endtask

  logic [31:0] rd;
  logic [1:0]  rr;
  int          p0;
  int          t;

  initial begin
    idle_bus();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset state
    check_val("rst_valids", {28'b0, axi.bvalid, axi.rvalid, axi.awready, axi.arready}, 32'h0);
    check_val("rst_rdata", axi.rdata, 32'h0);
    check_val("rst_pmod_wr", 32'(pmod_dac_wr), 32'h0);
    check_val("rst_outs", char_select | direct_ctrl | debug | pwm_clk_div | pwm_duty | pmod_dac,
              32'h0);
    for (int i = 0; i < 12; i++) begin
      axi_read(9'(i * 4), rd, rr);
      check_val($sformatf("rst_rd_%02h", i * 4), rd, RstExp[i]);
    end

    // Full-word writes to every RW register, then read back
    for (int i = 0; i < 6; i++) axi_write(RwAddr[i], 32'hDEAD_BEEF, 4'hF);
    for (int i = 0; i < 6; i++) begin
      axi_read(RwAddr[i], rd, rr);
      check_val($sformatf("rw_rd_%02h", RwAddr[i]), rd, 32'hDEAD_BEEF);
    end
    check_val("out_direct_ctrl", direct_ctrl, 32'hDEAD_BEEF);
    check_val("out_pmod_dac", pmod_dac, 32'hDEAD_BEEF);

    // Writes to RO registers are acknowledged but ignored
    p0 = pmod_pulses;
    axi_write(9'h04, 32'hFFFF_FFFF, 4'hF);
    axi_write(9'h28, 32'hFFFF_FFFF, 4'hF);
    axi_read(9'h04, rd, rr);
    check_val("ro_net", rd, NetVal);
    axi_read(9'h28, rd, rr);
    check_val("ro_cntr", rd, CntVal);
    repeat (2) step();
    check_val("ro_no_pulse", 32'(pmod_pulses - p0), 32'h0);

    // Strobes ignored with USE_WSTRB=0
    axi_write(9'h20, 32'hCAFE_F00D, 4'h1);
    check_val("wstrb_ignored", pwm_clk_div, 32'hCAFE_F00D);

    // Channel ordering
    split_write(9'h0C, 32'hA5A5_0001, 1'b1);
    check_val("aw_first_data", debug, 32'hA5A5_0001);
    split_write(9'h20, 32'h5A5A_0002, 1'b0);
    check_val("w_first_data", pwm_clk_div, 32'h5A5A_0002);

    // Back-pressure on B: no second write accepted while BVALID is stalled
    axi.bready = 1'b0;
    send_aw_w(9'h24, 32'h0000_1111, 4'hF);
    t = 0;
    while (!axi.bvalid && t < 10) begin step(); t++; end
    check_val("bp_first_data", pwm_duty, 32'h0000_1111);
    axi.awaddr = 9'h24; axi.wdata = 32'h0000_2222; axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("bp_hold", {29'b0, axi.bvalid, axi.awready, axi.wready}, 32'h4);
    end
    axi.bready = 1'b1;
    step();
    check_val("bp_release", 32'(axi.bvalid), 32'h0);
    check_val("bp_no_update", pwm_duty, 32'h0000_1111);
    send_aw_w(9'h24, 32'h0000_2222, 4'hF);
    wait_b();
    check_val("bp_second_data", pwm_duty, 32'h0000_2222);

    // PMOD DAC write strobe
    p0 = pmod_pulses;
    axi_write(9'h2C, 32'h0003_ABCD, 4'hF);
    repeat (3) step();
    check_val("pmod_value", pmod_dac, 32'h0003_ABCD);
    check_val("pmod_pulse_cnt", 32'(pmod_pulses - p0), 32'h1);

    // Read samples CHAR_SELECT in the cycle the write commits: old value returned
    axi.awaddr = 9'h00; axi.wdata = 32'h1234_5678; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    step();
    check_val("sim_ready", {30'b0, axi.awready, axi.wready}, 32'h3);
    axi.araddr = 9'h00; axi.arvalid = 1'b1;
    step();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    check_val("sim_arready", 32'(axi.arready), 32'h1);
    step();
    axi.arvalid = 1'b0;
    check_val("sim_rdata_old", axi.rdata, 32'hDEAD_BEEF);
    check_val("sim_r_b_valid", {30'b0, axi.rvalid, axi.bvalid}, 32'h3);
    check_val("sim_reg_new", char_select, 32'h1234_5678);
    step();
    check_val("sim_done", {30'b0, axi.rvalid, axi.bvalid}, 32'h0);

    // Unmapped reads
    axi_read(9'h30, rd, rr);
    check_val("unmapped_30", {rd[31:2], rr}, 32'h0);
    axi_read(9'h3C, rd, rr);
    check_val("unmapped_3c", rd, 32'h0);

    // Reset with only AW held: holding register must be discarded
    axi.awaddr = 9'h08; axi.awvalid = 1'b1;
    t = 0;
    while (!axi.awready && t < 10) begin step(); t++; end
    step();
    axi.awvalid = 1'b0;
    do_reset();
    check_val("rst_wr_outs", char_select | direct_ctrl | debug | pwm_clk_div | pwm_duty | pmod_dac,
              32'h0);
    split_write(9'h0C, 32'h0BAD_F00D, 1'b0);
    check_val("rst_wr_new_target", debug, 32'h0BAD_F00D);
    check_val("rst_wr_stale_target", direct_ctrl, 32'h0);

    // Reset while read data is stalled
    axi.rready = 1'b0; axi.araddr = 9'h04; axi.arvalid = 1'b1;
    t = 0;
    while (!axi.arready && t < 10) begin step(); t++; end
    step();
    axi.arvalid = 1'b0;
    step();
    check_val("mid_rd_hold", {axi.rdata[31:1], axi.rvalid}, {NetVal[31:1], 1'b1});
    rst_n = 1'b0;
    #1;
    check_val("mid_rd_async", 32'(axi.rvalid), 32'h0);
    step();
    rst_n = 1'b1;
    axi.rready = 1'b1;
    step();
    check_val("mid_rd_after", {31'b0, axi.rvalid} | axi.rdata, 32'h0);
    check_val("mid_rd_regs", debug | pwm_duty | pmod_dac, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
